output_normalizer: RTL and testbench
====================================

OUTPUT_NORMALIZER -- requirements
Module: output_normalizer

Interface
REQ-001 SHALL have parameter N_OUT, default 10, number of output-layer neurons (2..256).
REQ-002 SHALL have parameter DATA_W, default 16, width of unsigned neuron output values (Q8.8).
REQ-003 SHALL have parameter FRAC_W, default 16, fraction width of normalized result (Q0.FRAC_W).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to normalize the output layer.
REQ-007 SHALL have port busy  out  1  high from start acceptance through the DONE cycle.
REQ-008 SHALL have port done  out  1  one-cycle pulse at end of a run.
REQ-009 SHALL have port err_zero_sum  out  1  qualifies done; high when sum was zero.
REQ-010 SHALL have ports rd_en out 1, rd_addr out clog2(N_OUT), rd_data in DATA_W: neuron-output memory read, rd_data valid exactly 1 cycle after rd_en.
REQ-011 SHALL have ports wr_en out 1, wr_addr out clog2(N_OUT), wr_data out FRAC_W: in-place write-back of normalized value.

Function
REQ-012 SHALL accept start only in IDLE; start while busy ignored, no restart, no error.
REQ-013 SHALL use states IDLE, SUM_RD, SUM_LAST, CHECK, DIV_RD, DIV_LOAD, DIV_RUN, WR, DONE.
REQ-014 SUM_RD: N_OUT cycles, rd_en=1, rd_addr=0..N_OUT-1 ascending; each returned word added to sum the following cycle.
REQ-015 SUM_LAST: 1 cycle, accumulates final word; sum width DATA_W+clog2(N_OUT), never overflows.
REQ-016 CHECK: 1 cycle; sum==0 -> DONE with err_zero_sum=1, no writes; else DIV_RD with index 0.
REQ-017 DIV_RD: 1 cycle rd_en=1 at current index; DIV_LOAD: 1 cycle, captures rd_data, starts divider with dividend rd_data<<FRAC_W, divisor sum.
REQ-018 DIV_RUN: exactly DIV_CYC = DATA_W+FRAC_W cycles (one quotient bit per cycle, restoring).
REQ-019 WR: 1 cycle wr_en=1, wr_addr=index, wr_data=quotient saturated to 2^FRAC_W-1 when quotient >= 2^FRAC_W (value==sum).
REQ-020 After WR: index==N_OUT-1 -> DONE, else index+1 -> DIV_RD.
REQ-021 DONE: 1 cycle, done=1, busy=1, then IDLE; err_zero_sum=0 on successful runs.
REQ-022 Run length start-accept to done, nonzero sum: N_OUT+2+N_OUT*(DIV_CYC+3) cycles; zero sum: N_OUT+2.
REQ-023 rd_en and wr_en SHALL never be high in the same cycle; rd_addr/wr_addr/wr_data held 0 when their enable is low.
REQ-024 Quotient truncates (floor); no rounding.

Reset
REQ-025 rst SHALL force IDLE immediately, at any state including mid-divide.
REQ-026 Reset values: busy=0, done=0, err_zero_sum=0, rd_en=0, wr_en=0, addresses=0, wr_data=0, sum=0, index=0, divider cleared.
REQ-027 A run aborted by reset SHALL NOT resume; memory contents already written remain.

Structure
REQ-028 Shared package normalizer_pkg: state enum, FRAC_W default, DIV_CYC derivation function, saturation constant.
REQ-029 Sub-module serial_divider (start, dividend, divisor, busy, quotient; fixed DIV_CYC latency) SHALL hold the iterative divide.
REQ-030 Controller FSM, sum accumulator, index counter remain in output_normalizer.

Verification
REQ-031 N_OUT=4, mem={256,256,256,256}, start -> four writes of 0x4000 to addr 0..3, done at cycle 4+2+4*35=146, err_zero_sum=0.
REQ-032 mem={0,0,500,0} -> writes 0,0,0xFFFF,0 at addr 0..3, done pulse, err_zero_sum=0.
REQ-033 mem={0,0,0,0} -> no wr_en, done with err_zero_sum=1 at cycle 6.
REQ-034 mem={100,300,0,0}, second start pulsed during DIV_RUN -> ignored; writes 0x4000,0xC000,0,0, single done.
REQ-035 rst asserted during DIV_RUN of index 1 -> same cycle busy=0, rd_en=wr_en=0; only addr 0 written; next start runs full sequence.

Source files
------------

// File: rtl/normalizer_pkg.sv
// Shared definitions for the output-layer normalizer: controller states,
// default fraction width, divider latency and saturation value.
package normalizer_pkg;

  localparam int FRAC_W_DEFAULT = 16;

  // Largest Q0.16 fraction; a neuron that carries the whole sum maps here.
  localparam logic [FRAC_W_DEFAULT-1:0] SAT_DEFAULT = '1;

  typedef enum logic [3:0] {
    IDLE,
    SUM_RD,
    SUM_LAST,
    CHECK,
    DIV_RD,
    DIV_LOAD,
    DIV_RUN,
    WR,
    DONE
  } norm_state_e;

  // One quotient bit per dividend bit; the dividend is value << frac_w.
  function automatic int div_cycles(input int data_w, input int frac_w);
    return data_w + frac_w;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider: loads on start, then produces one quotient bit
// per clock for DIVIDEND_W clocks. busy is high while steps remain.
module serial_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DIVISOR_W:0]    rem_sh;
  logic [DIVISOR_W-1:0]  rem_diff;
  logic                  fits;

  // The remainder always stays below the divisor, so the difference fits
  // in DIVISOR_W bits whenever a subtraction is actually taken.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[DIVIDEND_W-1]};
    fits     = (rem_sh >= {1'b0, dsr_q});
    rem_diff = rem_sh[DIVISOR_W-1:0] - dsr_q;

    dvd_d = dvd_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    if (start) begin
      dvd_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
      cnt_d = CNT_W'(DIVIDEND_W);
    end else if (cnt_q != '0) begin
      dvd_d = {dvd_q[DIVIDEND_W-2:0], fits};
      rem_d = fits ? rem_diff : rem_sh[DIVISOR_W-1:0];
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign quotient = dvd_q;

endmodule

// File: rtl/output_normalizer.sv
// Normalizes the output layer in place: sums all neuron outputs, then writes
// back each value divided by the sum as a saturated Q0.FRAC_W fraction.
module output_normalizer
  import normalizer_pkg::*;
#(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16,
  parameter int FRAC_W = FRAC_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err_zero_sum,
  output logic                     rd_en,
  output logic [$clog2(N_OUT)-1:0] rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_en,
  output logic [$clog2(N_OUT)-1:0] wr_addr,
  output logic [FRAC_W-1:0]        wr_data
);

  localparam int ADDR_W  = $clog2(N_OUT);
  localparam int SUM_W   = DATA_W + ADDR_W;
  localparam int DIV_CYC = div_cycles(DATA_W, FRAC_W);
  localparam int CNT_W   = $clog2(DIV_CYC);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OUT - 1);
  localparam logic [FRAC_W-1:0] SAT_VAL  = '1;

  norm_state_e         state_q, state_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                err_q, err_d;

  logic                div_start;
  logic                div_busy;
  logic [DIV_CYC-1:0]  quotient;
  logic [FRAC_W-1:0]   frac_sat;

  serial_divider #(
    .DIVIDEND_W (DIV_CYC),
    .DIVISOR_W  (SUM_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({rd_data, {FRAC_W{1'b0}}}),
    .divisor  (sum_q),
    .busy     (div_busy),
    .quotient (quotient)
  );

  // Only value == sum produces a quotient of 1.0, which does not fit Q0.FRAC_W.
  assign frac_sat = (quotient[DIV_CYC-1:FRAC_W] != '0) ? SAT_VAL : quotient[FRAC_W-1:0];

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    run_cnt_d    = run_cnt_q;
    err_d        = err_q;
    busy         = 1'b1;
    done         = 1'b0;
    err_zero_sum = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    div_start    = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = SUM_RD;
          sum_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      SUM_RD: begin
        rd_en   = 1'b1;
        rd_addr = idx_q;
        // Read data lags the address by one cycle; nothing is pending at index 0.
        if (idx_q != '0) sum_d = sum_q + SUM_W'(rd_data);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = SUM_LAST;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      SUM_LAST: begin
        sum_d   = sum_q + SUM_W'(rd_data);
        state_d = CHECK;
      end
      CHECK: begin
        idx_d = '0;
        if (sum_q == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DIV_RD;
        end
      end
      DIV_RD: begin
        rd_en   = 1'b1;
        rd_addr = idx_q;
        state_d = DIV_LOAD;
      end
      DIV_LOAD: begin
        div_start = 1'b1;
        run_cnt_d = '0;
        state_d   = DIV_RUN;
      end
      DIV_RUN: begin
        if (run_cnt_q == CNT_W'(DIV_CYC - 1)) state_d = WR;
        else run_cnt_d = run_cnt_q + CNT_W'(1);
      end
      WR: begin
        // The divider has consumed all dividend bits by now.
        if (!div_busy) begin
          wr_en   = 1'b1;
          wr_addr = idx_q;
          wr_data = frac_sat;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = DIV_RD;
        end
      end
      DONE: begin
        done         = 1'b1;
        err_zero_sum = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      idx_q     <= '0;
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_output_normalizer.sv
// Scoreboard bench for output_normalizer with a 4-entry neuron memory.
module tb_output_normalizer;

  localparam int N_OUT  = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 16;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, err_zero_sum;
  logic              rd_en, wr_en;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [FRAC_W-1:0] wr_data;

  always #5 clk = ~clk;

  output_normalizer #(
    .N_OUT  (N_OUT),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err_zero_sum (err_zero_sum),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  // Neuron memory with one-cycle registered read and in-place write-back.
  logic [DATA_W-1:0] mem    [N_OUT];
  logic [DATA_W-1:0] init_v [N_OUT];
  logic              load = 1'b0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (load) begin
      for (int i = 0; i < N_OUT; i++) mem[i] <= init_v[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  typedef struct { logic [AW-1:0] a; logic [FRAC_W-1:0] d; } wr_t;
  typedef struct { logic err; int lat; } done_t;

  wr_t   wr_exp[$];
  done_t done_exp[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int lat      = 0;
  logic busy_prev = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: latency from start acceptance, bus hygiene, write and done scoreboards.
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
      lat       = 0;
    end else begin
      if (busy && !busy_prev) lat = 0;
      else if (busy) lat++;
      busy_prev = busy;

      chk("bus_idle_values",
          {63'd0, (rd_en && wr_en) || (!rd_en && rd_addr != '0) ||
                  (!wr_en && (wr_addr != '0 || wr_data != '0))}, 64'd0);

      if (wr_en) begin
        if (wr_exp.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d data=%0h, no write expected", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = wr_exp.pop_front();
          $display("write addr=%0d data=%04h (exp addr=%0d data=%04h)", wr_addr, wr_data, e.a, e.d);
          chk("write_addr", 64'(wr_addr), 64'(e.a));
          chk("write_data", 64'(wr_data), 64'(e.d));
        end
      end

      if (done) begin
        n_done++;
        if (done_exp.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_done: err=%0b latency=%0d, no done expected", err_zero_sum, lat);
        end else begin
          done_t e;
          e = done_exp.pop_front();
          $display("done err=%0b latency=%0d (exp err=%0b latency=%0d)", err_zero_sum, lat, e.err, e.lat);
          chk("done_err_zero_sum", 64'(err_zero_sum), 64'(e.err));
          chk("done_latency", 64'(lat), 64'(e.lat));
        end
      end
    end
  end

  task automatic load_mem(input logic [15:0] v0, input logic [15:0] v1,
                          input logic [15:0] v2, input logic [15:0] v3);
    init_v[0] = v0; init_v[1] = v1; init_v[2] = v2; init_v[3] = v3;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [FRAC_W-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wr_exp.push_back(e);
  endtask

  task automatic push_done(input logic err, input int l);
    done_t e;
    e.err = err;
    e.lat = l;
    done_exp.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int base;
    bit seen;
    base = n_done;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (n_done > base) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
    end
    repeat (3) @(negedge clk);
    chk({nm, "_idle_after"}, 64'(busy), 64'd0);
    chk({nm, "_writes_drained"}, 64'(wr_exp.size()), 64'd0);
    chk({nm, "_done_drained"}, 64'(done_exp.size()), 64'd0);
    wr_exp.delete();
    done_exp.delete();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy_done_err", {61'd0, busy, done, err_zero_sum}, 64'd0);
    chk("reset_enables", {62'd0, rd_en, wr_en}, 64'd0);
    chk("reset_bus", {30'd0, rd_addr, wr_addr, wr_data}, 64'd0);
    rst = 1'b0;

    // Equal outputs: each gets a quarter.
    load_mem(16'd256, 16'd256, 16'd256, 16'd256);
    for (int i = 0; i < 4; i++) push_wr(AW'(i), 16'h4000);
    push_done(1'b0, 146);
    pulse_start();
    wait_done("equal", 400);

    // One neuron holds the whole sum: saturates.
    load_mem(16'd0, 16'd0, 16'd500, 16'd0);
    push_wr(2'd0, 16'h0000);
    push_wr(2'd1, 16'h0000);
    push_wr(2'd2, 16'hFFFF);
    push_wr(2'd3, 16'h0000);
    push_done(1'b0, 146);
    pulse_start();
    wait_done("saturate", 400);

    // Zero sum: error done, no writes.
    load_mem(16'd0, 16'd0, 16'd0, 16'd0);
    push_done(1'b1, 6);
    pulse_start();
    wait_done("zero_sum", 100);

    // Start while busy is ignored.
    load_mem(16'd100, 16'd300, 16'd0, 16'd0);
    push_wr(2'd0, 16'h4000);
    push_wr(2'd1, 16'hC000);
    push_wr(2'd2, 16'h0000);
    push_wr(2'd3, 16'h0000);
    push_done(1'b0, 146);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done("restart_ignored", 400);

    // Reset during the divide of index 1.
    load_mem(16'd256, 16'd256, 16'd256, 16'd256);
    push_wr(2'd0, 16'h4000);
    pulse_start();
    repeat (55) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_enables", {62'd0, rd_en, wr_en}, 64'd0);
    chk("abort_writes_done", 64'(wr_exp.size()), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    chk("abort_mem0", 64'(mem[0]), 64'h4000);
    chk("abort_mem1", 64'(mem[1]), 64'd256);
    repeat (5) @(negedge clk);
    chk("abort_no_resume", 64'(busy), 64'd0);
    wr_exp.delete();
    done_exp.delete();

    // Fresh run over the partly written memory {0x4000,256,256,256}, sum 17152.
    push_wr(2'd0, 16'hF489);
    push_wr(2'd1, 16'h03D2);
    push_wr(2'd2, 16'h03D2);
    push_wr(2'd3, 16'h03D2);
    push_done(1'b0, 146);
    pulse_start();
    wait_done("after_abort", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
